// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared constants and types for the multicycle MIPS main control
//
// Purpose: opcode values, FSM state encoding, datapath select encodings and
//          the packed control word produced by mc_ctrl_outdec.
// Ports:   none (package).

package mc_pkg;

   // Instruction opcodes, IR[31:26]
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   // FSM states; the numeric value is what appears on state_o
   typedef enum logic [3:0] {
      S_RST    = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_REX    = 4'd7,
      S_RWB    = 4'd8,
      S_BEQ    = 4'd9,
      S_AIEX   = 4'd10,
      S_AIWB   = 4'd11,
      S_JMP    = 4'd12
   } state_t;

   // PC source select
   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   // ALU B operand select
   localparam logic [1:0] ALUB_REG    = 2'd0;
   localparam logic [1:0] ALUB_FOUR   = 2'd1;
   localparam logic [1:0] ALUB_IMM    = 2'd2;
   localparam logic [1:0] ALUB_IMM_SH = 2'd3;

   // ALU operation class
   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

   function automatic logic is_known_op(input logic [5:0] op);
      return (op == OP_R)   || (op == OP_LW)   || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - combinational state to control-word decoder
//
// Purpose: Moore decode of the main-control state into datapath controls.
//          ir_write/pc_write in FETCH follow mem_ready so the IR and PC load
//          only in the cycle the fetch completes; illegal flags an unknown
//          opcode while in DECODE.
// Ports:   state     in  4   current FSM state
//          opcode    in  6   IR[31:26]
//          mem_ready in  1   memory access completes this cycle
//          ctrl      out     packed control word

module mc_ctrl_outdec
   import mc_pkg::*;
(
   input  logic [3:0] state,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = ALUB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PC_SRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            // Branch target is precomputed into ALUOut here
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = ALUB_IMM_SH;
            ctrl.alu_op    = ALU_ADD;
            ctrl.illegal   = ~is_known_op(opcode);
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_REX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_REG;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_RWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b1;
            ctrl.mem_to_reg = 1'b0;
         end
         S_BEQ: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = ALUB_REG;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PC_SRC_ALUOUT;
         end
         S_AIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = ALUB_IMM;
            ctrl.alu_op    = ALU_ADD;
         end
         S_AIWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = 1'b0;
         end
         S_JMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_SRC_JUMP;
         end
         default: ;   // RST and unused encodings: everything off
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS main-control FSM
//
// Purpose: sequences fetch/decode/execute/memory/writeback over a shared
//          memory datapath with variable memory wait states. Optional
//          performance counters are built when MC_CTRL_PERF_EN is defined.
// Ports:   clk, rst_n (async active-low)
//          opcode[6], zero, mem_ready                      inputs
//          pc_write, pc_write_cond, pc_src[2], iord,
//          mem_read, mem_write, ir_write, reg_dst,
//          mem_to_reg, reg_write, alu_src_a, alu_src_b[2],
//          alu_op[2], illegal, state_o[4]                  outputs
//          cyc_cnt[CNT_W], instr_cnt[CNT_W]                outputs (MC_CTRL_PERF_EN)

module mc_ctrl
   import mc_pkg::*;
`ifdef MC_CTRL_PERF_EN
#(
   parameter int CNT_W = 32
)
`endif
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       pc_src,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             illegal,
   output logic [3:0]       state_o
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   state_t state;
   state_t next_state;
   ctrl_t  ctrl;

   // zero qualifies pc_write_cond inside the datapath; the FSM never needs it
   logic unused_zero;
   assign unused_zero = zero;

   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_RST:    next_state = S_FETCH;
         S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_REX;
               OP_BEQ:       next_state = S_BEQ;
               OP_ADDI:      next_state = S_AIEX;
               OP_J:         next_state = S_JMP;
               default:      next_state = S_FETCH;
            endcase
         end
         S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  next_state = S_FETCH;
         S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
         S_REX:    next_state = S_RWB;
         S_RWB:    next_state = S_FETCH;
         S_BEQ:    next_state = S_FETCH;
         S_AIEX:   next_state = S_AIWB;
         S_AIWB:   next_state = S_FETCH;
         S_JMP:    next_state = S_FETCH;
         default:  next_state = S_FETCH;
      endcase
   end

   // Async reset lands in RST, whose decode is all-zero, so any in-flight
   // memory request drops the instant rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_RST;
      else        state <= next_state;
   end

   mc_ctrl_outdec u_outdec (
      .state     (state),
      .opcode    (opcode),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign pc_src        = ctrl.pc_src;
   assign iord          = ctrl.iord;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign ir_write      = ctrl.ir_write;
   assign reg_dst       = ctrl.reg_dst;
   assign mem_to_reg    = ctrl.mem_to_reg;
   assign reg_write     = ctrl.reg_write;
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign alu_op        = ctrl.alu_op;
   assign illegal       = ctrl.illegal;
   assign state_o       = state;

`ifdef MC_CTRL_PERF_EN
   // An instruction retires on any entry into FETCH except the one out of RST
   // (and except FETCH holding during a fetch wait); the illegal path retires too.
   logic retire;
   assign retire = (state != S_RST) && (state != S_FETCH) && (next_state == S_FETCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt   <= '0;
         instr_cnt <= '0;
      end else begin
         if (state != S_RST) cyc_cnt <= cyc_cnt + CNT_W'(1);
         if (retire)         instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle main-control FSM for the MIPS processor.
- Sequences a shared-memory datapath (PC, IR, register file, ALU, unified memory) through fetch, decode, execute, memory and writeback steps.
- Supports a memory with variable wait states.
- Replaces the single-cycle fetch path. PC update, branch and jump selection are driven from this block's enables.

Parameters:
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero (beq).
- pc_src  out  2  PC source: 0=ALU result (pc+4), 1=ALUOut (branch target), 2=jump target {pc[31:28],addr26,2'b00}.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination select: 0=rt, 1=rd.
- mem_to_reg  out  1  write-data select: 0=ALUOut, 1=MDR.
- reg_write  out  1  register-file write.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B select: 0=B register, 1=const 4, 2=sign-extended imm, 3=sign-extended imm<<2.
- alu_op  out  2  ALU op class: 0=add, 1=sub, 2=funct-decoded.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- state_o  out  4  current state, for debug.

Behaviour:
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- Reset:
  - rst_n low forces state RST asynchronously.
  - Every output except state_o is 0 while in RST; state_o=0.
  - RST -> FETCH unconditionally on the first clk after rst_n rises.
- Outputs are Moore, decoded from state only. Exceptions: ir_write, pc_write and illegal are additionally qualified as listed below.
- States (state_o encoding in parentheses):
  - RST(0): all outputs 0; next FETCH.
  - FETCH(1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(2): alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state by opcode:
    - LW/SW -> MEMADR
    - R -> REX
    - BEQ -> BEQ
    - ADDI -> AIEX
    - J -> JMP
    - other -> FETCH, with illegal=1 for this cycle.
  - MEMADR(3): alu_src_a=1, alu_src_b=2, alu_op=0. LW -> MEMRD; SW -> MEMWR.
  - MEMRD(4): mem_read=1, iord=1. Hold until mem_ready=1, then MEMWB.
  - MEMWB(5): reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
  - MEMWR(6): mem_write=1, iord=1. Hold until mem_ready=1, then FETCH.
  - REX(7): alu_src_a=1, alu_src_b=0, alu_op=2. Next RWB.
  - RWB(8): reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
  - BEQ(9): alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1. Next FETCH.
  - AIEX(10): alu_src_a=1, alu_src_b=2, alu_op=0. Next AIWB.
  - AIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
  - JMP(12): pc_write=1, pc_src=2. Next FETCH.
  - Encodings 13-15 -> FETCH, all outputs 0.
- Write-enable exclusivity: mem_read and mem_write are never both 1. reg_write is never 1 in a cycle where mem_write=1.
- Memory wait states: unbounded; no timeout. Memory requests stay asserted and stable throughout a wait.
- Reset mid-access: any in-flight memory request drops in the same cycle rst_n falls (asynchronous).
- Latency with zero wait states:
  - LW 5 cycles; R, ADDI and SW 4; BEQ and J 3.
  - Each wait state adds 1 cycle.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined:
  - Adds outputs cyc_cnt[CNT_W] and instr_cnt[CNT_W], both reset to 0.
  - cyc_cnt increments every cycle not in RST.
  - instr_cnt increments on each transition into FETCH from a non-RST, non-FETCH state. The illegal path counts as well.
  - Both counters wrap modulo 2^CNT_W.
- Undefined: ports absent; no counter logic.

Decomposition:
- Package mc_pkg:
  - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - state encoding constants
  - pc_src, alu_src_b and alu_op encodings
- Sub-module: mc_ctrl_outdec, the combinational state -> control-word decoder. The FSM register and next-state logic stay in mc_ctrl.

Test Plan:
- Reset: rst_n=0 mid-MEMRD -> state_o=0 and all outputs 0 immediately; after rst_n=1, FETCH on the next edge with mem_read=1.
- LW opcode 100011, mem_ready always 1 -> states 1,2,3,4,5,1; reg_write=1 only in state 5 with mem_to_reg=1.
- SW with mem_ready low for 3 cycles in MEMWR -> mem_write held for 4 cycles, iord=1 throughout; reg_write never 1.
- FETCH with mem_ready=0 for 2 cycles then 1 -> ir_write and pc_write pulse exactly once, in the mem_ready cycle.
- BEQ with zero=1 and with zero=0 -> pc_write_cond=1, pc_src=1 in state 9; return to FETCH after 3 cycles in both cases.
- Opcode 111111 -> illegal=1 for one cycle in DECODE, next state FETCH; with MC_CTRL_PERF_EN, instr_cnt increments by 1.
